// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: chain of STAGES elastic register slices, each a main
// register plus a skid register, joined by a valid/ready handshake.
// Back-pressure stalls only the slices behind the blocking point; flush
// empties every slice at once.
// Build macro PIPE_ELASTIC_OCC_EN adds a registered 'occupancy' output that
// counts the beats held across all slices.
module pipe_elastic_reg #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_ELASTIC_OCC_EN
   ,
   output logic [$clog2(2*STAGES+1)-1:0] occupancy
`endif
);

   // Bit 0 = slice holds a beat (valid), bit 1 = skid occupied (not ready),
   // so both handshake outputs of a slice are plain register bits.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b11
   } slice_state_t;

   // Chain links: index i is the boundary in front of slice i; index STAGES
   // is the pipe output.
   logic [STAGES:0]            w_valid_ext;
   logic [STAGES:0]            w_ready_ext;
   logic [STAGES:0][WIDTH-1:0] w_data_ext;

   assign w_valid_ext[0]      = in_valid;
   assign w_data_ext[0]       = in_data;
   assign w_ready_ext[STAGES] = out_ready;

   assign in_ready  = w_ready_ext[0];
   assign out_valid = w_valid_ext[STAGES];
   assign out_data  = w_data_ext[STAGES];

   for (genvar g = 0; g < STAGES; g++) begin : g_slice
      slice_state_t     r_state;
      slice_state_t     w_state_nxt;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             w_accept;
      logic             w_take;

      assign w_valid_ext[g+1] = r_state[0];
      assign w_ready_ext[g]   = ~r_state[1];
      assign w_data_ext[g+1]  = r_main;

      assign w_accept = w_valid_ext[g] & w_ready_ext[g];
      assign w_take   = w_valid_ext[g+1] & w_ready_ext[g+1];

      // Next-state: beat count in main/skid after this edge's handshakes
      always_comb begin
         w_state_nxt = r_state;
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
               if (w_accept && !w_take)      w_state_nxt = ST_FULL;
               else if (!w_accept && w_take) w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
               if (w_take) w_state_nxt = ST_BUSY;
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end

      // State register; reset and flush both empty the slice
      always_ff @(posedge clk) begin
         if (!reset_n)   r_state <= ST_EMPTY;
         else if (flush) r_state <= ST_EMPTY;
         else            r_state <= w_state_nxt;
      end

      // Payload registers; cleared by reset, frozen across a flush
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            r_main <= '0;
            r_skid <= '0;
         end else if (!flush) begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_accept) r_main <= w_data_ext[g];
               end
               ST_BUSY: begin
                  if (w_accept && w_take) r_main <= w_data_ext[g];
                  else if (w_accept)      r_skid <= w_data_ext[g];
               end
               ST_FULL: begin
                  if (w_take) r_main <= r_skid;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PIPE_ELASTIC_OCC_EN
   localparam int unsigned OCC_W = $clog2(2*STAGES+1);

   logic [OCC_W-1:0] r_occ;
   logic             w_in_hs;
   logic             w_out_hs;

   assign w_in_hs   = in_valid & in_ready;
   assign w_out_hs  = out_valid & out_ready;
   assign occupancy = r_occ;

   // Beats in flight: +1 per accept, -1 per delivery, zero after flush
   always_ff @(posedge clk) begin
      if (!reset_n || flush)        r_occ <= '0;
      else if (w_in_hs && !w_out_hs) r_occ <= r_occ + OCC_W'(1);
      else if (!w_in_hs && w_out_hs) r_occ <= r_occ - OCC_W'(1);
   end
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg: directed tests for pipe_elastic_reg on four instances
// (STAGES = 1..4); a queue scoreboard checks every delivered beat.
module tb_pipe_elastic_reg;

   localparam int unsigned W     = 16;
   localparam int unsigned N_DUT = 4;

   logic             clk;
   logic             reset_n;
   logic             flush;
   logic [N_DUT-1:0] in_valid;
   logic [N_DUT-1:0] in_ready;
   logic [N_DUT-1:0] out_valid;
   logic [N_DUT-1:0] out_ready;
   logic [W-1:0]     in_data  [N_DUT];
   logic [W-1:0]     out_data [N_DUT];
`ifdef PIPE_ELASTIC_OCC_EN
   logic [3:0]       occ      [N_DUT];
`endif

   for (genvar k = 0; k < N_DUT; k++) begin : g_dut
`ifdef PIPE_ELASTIC_OCC_EN
      localparam int unsigned OW = $clog2(2*(k+1)+1);
      logic [OW-1:0] w_occ;
      assign occ[k] = 4'(w_occ);
`endif
      pipe_elastic_reg #(.WIDTH(W), .STAGES(k+1)) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .flush     (flush),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_data   (in_data[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_data  (out_data[k])
`ifdef PIPE_ELASTIC_OCC_EN
         ,
         .occupancy (w_occ)
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_tests;
   int           n_fail;
   logic [1:0]   sel;
   logic [W-1:0] sb_q [$];
   int           edge_no;
   int           n_in;
   int           n_out;
   int           first_in;
   int           first_out;
   int           last_out;
   logic         last_ihs;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of the selected instance: scoreboard update, edge, hold check
   task automatic tick();
      logic         ihs;
      logic         ohs;
      logic         ov_pre;
      logic [W-1:0] od_pre;
      logic [31:0]  exp;
      ihs    = in_valid[sel] & in_ready[sel];
      ohs    = out_valid[sel] & out_ready[sel];
      ov_pre = out_valid[sel];
      od_pre = out_data[sel];
      edge_no++;
      last_ihs = 1'b0;
      if (!reset_n) begin
         sb_q.delete();
      end else begin
         if (ohs === 1'b1) begin
            exp = (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hBAD0_BAD0;
            check_eq("sb_data", 32'(out_data[sel]), exp);
            n_out++;
            if (first_out < 0) first_out = edge_no;
            last_out = edge_no;
         end
         if (flush) begin
            sb_q.delete();
         end else if (ihs === 1'b1) begin
            sb_q.push_back(in_data[sel]);
            last_ihs = 1'b1;
            n_in++;
            if (first_in < 0) first_in = edge_no;
         end
      end
      @(posedge clk);
      #1;
      if (reset_n && !flush && ov_pre === 1'b1 && ohs !== 1'b1) begin
         check_eq("hold_valid", 32'(out_valid[sel]), 32'd1);
         check_eq("hold_data",  32'(out_data[sel]),  32'(od_pre));
      end
`ifdef PIPE_ELASTIC_OCC_EN
      check_eq("occupancy", 32'(occ[sel]), 32'(sb_q.size()));
`endif
   endtask

   task automatic reset_pipe();
      in_valid[sel]  = 1'b0;
      out_ready[sel] = 1'b0;
      flush          = 1'b0;
      reset_n        = 1'b0;
      tick();
      reset_n        = 1'b1;
      n_in = 0; n_out = 0; first_in = -1; first_out = -1; last_out = -1;
   endtask

   initial begin
      logic [1:0] idx;
      n_tests = 0; n_fail = 0; edge_no = 0;
      n_in = 0; n_out = 0; first_in = -1; first_out = -1; last_out = -1;
      sel = 2'd0; last_ihs = 1'b0;
      flush = 1'b0; reset_n = 1'b0;
      out_ready = '0;

      // Reset held two cycles with a valid beat offered to every instance
      in_valid = '1;
      for (int k = 0; k < N_DUT; k++) in_data[k] = 16'hDEAD;
      repeat (2) begin
         tick();
         check_eq("rst_in_ready",  32'(in_ready),  32'hF);
         check_eq("rst_out_valid", 32'(out_valid), 32'h0);
         for (int k = 0; k < N_DUT; k++) begin
            idx = 2'(k);
            check_eq("rst_out_data", 32'(out_data[idx]), 32'h0);
         end
      end
      in_valid = '0;
      reset_n  = 1'b1;
      tick();
      check_eq("rst_no_accept", 32'(out_valid), 32'h0);

      // Streaming through STAGES=3
      sel = 2'd2;
      reset_pipe();
      out_ready[sel] = 1'b1;
      begin
         int first_ov;
         first_ov = -1;
         for (int c = 0; c < 40 && n_out < 10; c++) begin
            in_valid[sel] = (n_in < 10);
            in_data[sel]  = W'(256 + n_in);
            if (in_valid[sel]) check_eq("stream_in_ready", 32'(in_ready[sel]), 32'd1);
            tick();
            if (out_valid[sel] === 1'b1 && first_ov < 0) first_ov = edge_no;
         end
         in_valid[sel] = 1'b0;
         check_eq("stream_count",   32'(n_out), 32'd10);
         check_eq("stream_latency", 32'(first_ov - first_in), 32'd2);
         check_eq("stream_first",   32'(first_out - first_in), 32'd3);
         check_eq("stream_no_gap",  32'(last_out - first_out), 32'd9);
      end

      // Back-pressure on STAGES=2: capacity of four beats
      sel = 2'd1;
      reset_pipe();
      for (int c = 1; c <= 8; c++) begin
         in_valid[sel] = 1'b1;
         in_data[sel]  = W'(n_in + 1);
         check_eq("bp_in_ready", 32'(in_ready[sel]), 32'(c <= 4));
         tick();
      end
      check_eq("bp_accepted", 32'(n_in), 32'd4);
      check_eq("bp_head_valid", 32'(out_valid[sel]), 32'd1);
      check_eq("bp_head_data",  32'(out_data[sel]),  32'h1);
      out_ready[sel] = 1'b1;
      for (int c = 0; c < 40 && n_out < 8; c++) begin
         in_valid[sel] = (n_in < 8);
         in_data[sel]  = W'(n_in + 1);
         tick();
      end
      in_valid[sel] = 1'b0;
      check_eq("bp_count",  32'(n_out), 32'd8);
      check_eq("bp_no_gap", 32'(last_out - first_out), 32'd7);

      // Random valid / ready at 50% on every depth
      for (int s = 0; s < N_DUT; s++) begin
         sel = 2'(s);
         reset_pipe();
         for (int c = 0; c < 2000; c++) begin
            if (!in_valid[sel] || last_ihs) in_valid[sel] = 1'($urandom_range(1, 0));
            in_data[sel]   = W'(16384 + n_in);
            out_ready[sel] = 1'($urandom_range(1, 0));
            tick();
         end
         in_valid[sel]  = 1'b0;
         out_ready[sel] = 1'b1;
         repeat (12) tick();
         check_eq("rand_drained",  32'(sb_q.size()), 32'd0);
         check_eq("rand_in_eq_out", 32'(n_out), 32'(n_in));
         check_eq("rand_traffic",  32'(n_in > 200), 32'd1);
         out_ready[sel] = 1'b0;
      end

      // Flush with a full STAGES=2 pipe
      sel = 2'd1;
      reset_pipe();
      for (int c = 0; c < 10 && n_in < 4; c++) begin
         in_valid[sel] = 1'b1;
         in_data[sel]  = W'(17 + n_in);
         tick();
      end
      check_eq("fl_full", 32'(in_ready[sel]), 32'd0);
      flush          = 1'b1;
      in_valid[sel]  = 1'b1;
      in_data[sel]   = 16'h0055;
      out_ready[sel] = 1'b1;
      check_eq("fl_head_valid", 32'(out_valid[sel]), 32'd1);
      check_eq("fl_head_data",  32'(out_data[sel]),  32'h11);
      tick();
      flush         = 1'b0;
      in_valid[sel] = 1'b0;
      check_eq("fl_delivered", 32'(n_out), 32'd1);
      check_eq("fl_out_valid", 32'(out_valid[sel]), 32'd0);
      check_eq("fl_in_ready",  32'(in_ready[sel]),  32'd1);
      repeat (5) begin
         tick();
         check_eq("fl_quiet", 32'(out_valid[sel]), 32'd0);
      end

      // Flush swallowing an accepted input beat
      out_ready[sel] = 1'b0;
      in_valid[sel]  = 1'b1;
      in_data[sel]   = 16'h0021;
      tick();
      flush         = 1'b1;
      in_data[sel]  = 16'h0066;
      check_eq("fl2_in_ready", 32'(in_ready[sel]), 32'd1);
      tick();
      flush          = 1'b0;
      in_valid[sel]  = 1'b0;
      out_ready[sel] = 1'b1;
      check_eq("fl2_out_valid", 32'(out_valid[sel]), 32'd0);
      check_eq("fl2_in_ready2", 32'(in_ready[sel]),  32'd1);
      repeat (4) begin
         tick();
         check_eq("fl2_quiet", 32'(out_valid[sel]), 32'd0);
      end

      // Reset mid-stream on STAGES=2, then a fresh beat
      reset_pipe();
      for (int c = 0; c < 10 && n_in < 3; c++) begin
         in_valid[sel] = 1'b1;
         in_data[sel]  = W'(49 + n_in);
         tick();
      end
      in_valid[sel] = 1'b0;
      check_eq("mr_pre_valid", 32'(out_valid[sel]), 32'd1);
`ifdef PIPE_ELASTIC_OCC_EN
      check_eq("mr_occ3", 32'(occ[sel]), 32'd3);
`endif
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_eq("mr_out_valid", 32'(out_valid[sel]), 32'd0);
      check_eq("mr_in_ready",  32'(in_ready[sel]),  32'd1);
      check_eq("mr_out_data",  32'(out_data[sel]),  32'd0);
`ifdef PIPE_ELASTIC_OCC_EN
      check_eq("mr_occ0", 32'(occ[sel]), 32'd0);
`endif
      n_out = 0;
      in_valid[sel]  = 1'b1;
      in_data[sel]   = 16'h00A7;
      out_ready[sel] = 1'b1;
      tick();
      in_valid[sel] = 1'b0;
      check_eq("mr_lat1_valid", 32'(out_valid[sel]), 32'd0);
`ifdef PIPE_ELASTIC_OCC_EN
      check_eq("mr_lat1_occ", 32'(occ[sel]), 32'd1);
`endif
      tick();
      check_eq("mr_lat2_valid", 32'(out_valid[sel]), 32'd1);
      check_eq("mr_lat2_data",  32'(out_data[sel]),  32'hA7);
`ifdef PIPE_ELASTIC_OCC_EN
      check_eq("mr_lat2_occ", 32'(occ[sel]), 32'd1);
`endif
      tick();
      check_eq("mr_done_valid", 32'(out_valid[sel]), 32'd0);
      check_eq("mr_done_count", 32'(n_out), 32'd1);
`ifdef PIPE_ELASTIC_OCC_EN
      check_eq("mr_done_occ", 32'(occ[sel]), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
